seg7_disp_arb: RTL and testbench

- Shares the 8-digit seven-segment display driver between up to four requesters, e.g. CPU MMIO store, PC trace, instruction trace and register debug.
- Arbitrates round-robin with a minimum display dwell time so each granted value stays readable.
- Supports a switch-driven "pin" mode that locks the display to one source.
- Drives the display driver's cs/data inputs; sits between the SoC debug sources and the display driver in the FPGA top.

---
 rtl/seg7_arb_pkg.sv | 13 +
 rtl/seg7_rr_pick.sv | 27 ++
 rtl/seg7_disp_arb.sv | 108 ++++++++++
 tb/tb_seg7_disp_arb.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_arb_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package seg7_arb_pkg;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned IDX_W = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/seg7_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping modulo NREQ.
module seg7_rr_pick
    import seg7_arb_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        // i = NREQ-1 wraps back to 'last' itself, so it is lowest priority
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = last + IDX_W'(i + 1);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/seg7_disp_arb.sv
// Round-robin arbiter with minimum dwell and pin mode, feeding the 8-digit display driver.
module seg7_disp_arb
    import seg7_arb_pkg::state_t, seg7_arb_pkg::S_IDLE, seg7_arb_pkg::S_GRANT,
           seg7_arb_pkg::S_HOLD, seg7_arb_pkg::IDX_W;
#(
    parameter int unsigned        NREQ        = 4,
    parameter int unsigned        HOLD_W      = 24,
    parameter logic [HOLD_W-1:0]  HOLD_CYCLES = 24'd10_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [32*NREQ-1:0]   i_data,
    input  logic                 pin_en,
    input  logic [IDX_W-1:0]     pin_sel,
    output logic [NREQ-1:0]      ack,
    output logic                 o_cs,
    output logic [31:0]          o_data,
    output logic [IDX_W-1:0]     o_owner,
    output logic                 o_busy
);

    localparam logic [HOLD_W-1:0] HOLD_LOAD =
        (HOLD_CYCLES > HOLD_W'(1)) ? HOLD_CYCLES - HOLD_W'(1) : '0;

    state_t             state, state_nx;
    logic [IDX_W-1:0]   last;
    logic [HOLD_W-1:0]  cnt;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   gnt_idx;

    logic               cs_nx;
    logic               busy_nx;
    logic [NREQ-1:0]    ack_nx;
    logic [31:0]        data_nx;

    seg7_rr_pick u_pick (
        .req   (req),
        .last  (last),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        gnt_idx  = o_owner;
        case (state)
            S_IDLE: begin
                if (pin_en) begin
                    if (req[pin_sel]) begin
                        state_nx = S_GRANT;
                        gnt_idx  = pin_sel;
                    end
                end else if (pick_valid) begin
                    state_nx = S_GRANT;
                    gnt_idx  = pick_idx;
                end
            end
            S_GRANT: state_nx = S_HOLD;
            S_HOLD: begin
                // Priority: pin abort, then owner refresh, then dwell expiry
                if (pin_en && pin_sel != o_owner) state_nx = S_IDLE;
                else if (req[o_owner])            state_nx = S_GRANT;
                else if (cnt == '0)               state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe
    always_comb begin
        cs_nx   = (state_nx == S_GRANT);
        busy_nx = (state_nx != S_IDLE);
        ack_nx  = cs_nx ? (NREQ'(1) << gnt_idx) : '0;
        data_nx = cs_nx ? i_data[32*gnt_idx +: 32] : o_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_cs    <= 1'b0;
            ack     <= '0;
            o_data  <= '0;
            o_owner <= '0;
            o_busy  <= 1'b0;
            last    <= '1;
            cnt     <= '0;
        end else begin
            o_cs    <= cs_nx;
            ack     <= ack_nx;
            o_data  <= data_nx;
            o_owner <= gnt_idx;
            o_busy  <= busy_nx;
            if (state == S_GRANT) begin
                last <= o_owner;
                cnt  <= HOLD_LOAD;
            end else if (state == S_HOLD && cnt != '0) begin
                cnt  <= cnt - HOLD_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seg7_disp_arb.sv
// Directed bench for seg7_disp_arb: short-dwell build plus a zero-dwell build.
module tb_seg7_disp_arb;

    logic         clk = 1'b0;
    logic         rst = 1'b1;

    logic [3:0]   req = '0;
    logic [127:0] i_data = '0;
    logic         pin_en = 1'b0;
    logic [1:0]   pin_sel = '0;
    logic [3:0]   ack;
    logic         o_cs;
    logic [31:0]  o_data;
    logic [1:0]   o_owner;
    logic         o_busy;

    logic [3:0]   req_z = '0;
    logic [127:0] i_data_z = '0;
    logic         pin_en_z = 1'b0;
    logic [1:0]   pin_sel_z = '0;
    logic [3:0]   ack_z;
    logic         o_cs_z;
    logic [31:0]  o_data_z;
    logic [1:0]   o_owner_z;
    logic         o_busy_z;

    int n_chk  = 0;
    int n_pass = 0;
    int gap;

    always #5 clk = ~clk;

    seg7_disp_arb #(.NREQ(4), .HOLD_W(24), .HOLD_CYCLES(24'd4)) u_dut (
        .clk(clk), .rst(rst), .req(req), .i_data(i_data),
        .pin_en(pin_en), .pin_sel(pin_sel), .ack(ack), .o_cs(o_cs),
        .o_data(o_data), .o_owner(o_owner), .o_busy(o_busy)
    );

    seg7_disp_arb #(.NREQ(4), .HOLD_W(24), .HOLD_CYCLES(24'd0)) u_dut_z (
        .clk(clk), .rst(rst), .req(req_z), .i_data(i_data_z),
        .pin_en(pin_en_z), .pin_sel(pin_sel_z), .ack(ack_z), .o_cs(o_cs_z),
        .o_data(o_data_z), .o_owner(o_owner_z), .o_busy(o_busy_z)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Counts negedges until o_cs is seen, up to max
    task automatic wait_cs(input int max, output int n);
        n = 0;
        while (o_cs !== 1'b1 && n < max) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && o_busy !== 1'b0; i++) tick();
        chk("idle_reached", {31'd0, o_busy}, 32'd0);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_cs",    {31'd0, o_cs},    32'd0);
        chk("rst_ack",   {28'd0, ack},     32'd0);
        chk("rst_data",  o_data,           32'd0);
        chk("rst_owner", {30'd0, o_owner}, 32'd0);
        chk("rst_busy",  {31'd0, o_busy},  32'd0);
        rst = 1'b0;
        tick();

        // 1: single request, 1-cycle latency, busy for GRANT + 4 HOLD cycles
        req = 4'b0001;
        i_data[31:0] = 32'h1234_5678;
        tick();
        chk("t1_cs",    {31'd0, o_cs},    32'd1);
        chk("t1_ack",   {28'd0, ack},     32'h1);
        chk("t1_data",  o_data,           32'h1234_5678);
        chk("t1_owner", {30'd0, o_owner}, 32'd0);
        req = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_hold_busy", {31'd0, o_busy}, 32'd1);
            chk("t1_hold_cs",   {31'd0, o_cs},   32'd0);
        end
        tick();
        chk("t1_busy_end", {31'd0, o_busy}, 32'd0);

        // 2: two requests from reset exit, order 1 then 3
        pulse_rst();
        req = 4'b1010;
        i_data[63:32]   = 32'h1111_1111;
        i_data[127:96]  = 32'h3333_3333;
        tick();
        chk("t2_ack1",  {28'd0, ack}, 32'h2);
        chk("t2_data1", o_data,       32'h1111_1111);
        req = 4'b1000;
        tick();
        chk("t2_ack1_single", {28'd0, ack}, 32'h0);
        wait_cs(20, gap);
        chk("t2_gap",   gap + 1,          32'd6);
        chk("t2_ack3",  {28'd0, ack},     32'h8);
        chk("t2_data3", o_data,           32'h3333_3333);
        chk("t2_own3",  {30'd0, o_owner}, 32'd3);
        req = '0;
        tick();
        chk("t2_ack3_single", {28'd0, ack}, 32'h0);
        wait_idle();

        // 3: owner refresh restarts dwell; pending requester 2 waits
        req = 4'b0010;
        i_data[63:32] = 32'hAAAA_0001;
        tick();
        chk("t3_ack1", {28'd0, ack}, 32'h2);
        req = '0;
        tick();
        req = 4'b0110;
        i_data[63:32] = 32'hDEAD_BEEF;
        i_data[95:64] = 32'h2222_2222;
        tick();
        chk("t3_refresh_ack",  {28'd0, ack}, 32'h2);
        chk("t3_refresh_data", o_data,       32'hDEAD_BEEF);
        req = 4'b0100;
        tick();
        wait_cs(20, gap);
        chk("t3_gap",   gap + 1,      32'd6);
        chk("t3_ack2",  {28'd0, ack}, 32'h4);
        chk("t3_data2", o_data,       32'h2222_2222);
        req = '0;
        wait_idle();

        // 4: pin abort beats owner refresh; pinned requester then wins
        req = 4'b0001;
        i_data[31:0] = 32'h0000_00A0;
        tick();
        chk("t4_ack0", {28'd0, ack}, 32'h1);
        req = '0;
        tick();
        pin_en  = 1'b1;
        pin_sel = 2'd2;
        req     = 4'b0001;
        tick();
        chk("t4_abort_busy", {31'd0, o_busy}, 32'd0);
        chk("t4_abort_cs",   {31'd0, o_cs},   32'd0);
        tick();
        chk("t4_pin_nogrant", {28'd0, ack}, 32'h0);
        req = 4'b0101;
        i_data[95:64] = 32'h0000_0C02;
        tick();
        chk("t4_pin_ack",  {28'd0, ack},     32'h4);
        chk("t4_pin_own",  {30'd0, o_owner}, 32'd2);
        chk("t4_pin_data", o_data,           32'h0000_0C02);
        req    = '0;
        pin_en = 1'b0;
        wait_idle();

        // 6: reset during a GRANT whose last pointer is already 0
        req = 4'b0001;
        i_data[31:0] = 32'h6000_0000;
        tick();
        req = '0;
        tick();
        req = 4'b0001;
        i_data[31:0] = 32'h6000_0001;
        tick();
        chk("t6_pre_cs", {31'd0, o_cs}, 32'd1);
        req = '0;
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_cs",   {31'd0, o_cs},    32'd0);
        chk("t6_rst_ack",  {28'd0, ack},     32'h0);
        chk("t6_rst_busy", {31'd0, o_busy},  32'd0);
        chk("t6_rst_data", o_data,           32'd0);
        chk("t6_rst_own",  {30'd0, o_owner}, 32'd0);
        tick();
        rst = 1'b0;
        req = 4'b0011;
        i_data[31:0]  = 32'h0600_0000;
        i_data[63:32] = 32'h0611_1111;
        tick();
        chk("t6_first_ack",  {28'd0, ack}, 32'h1);
        chk("t6_first_data", o_data,       32'h0600_0000);
        req = '0;
        wait_idle();

        // 5: zero dwell build, held request refreshes every 2 cycles
        req_z = 4'b0001;
        i_data_z[31:0] = 32'h5500_0001;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("t5_cs",   {31'd0, o_cs_z},   (k % 2 == 1) ? 32'd1 : 32'd0);
            chk("t5_busy", {31'd0, o_busy_z}, 32'd1);
            if (k == 3) chk("t5_data", o_data_z, 32'h5500_0002);
            if (k == 2) i_data_z[31:0] = 32'h5500_0002;
        end
        req_z = '0;
        tick();
        chk("t5_idle", {31'd0, o_busy_z}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
